// File: rtl/gearbox_tx_gen_pkg.sv
// Shared constants for the 64b/66b transmit gearbox: block geometry defaults,
// sync-header codes and the buffer sizing helper.
package gearbox_pkg;

   localparam int DEF_BLOCK_W = 64;
   localparam int DEF_HEAD_W  = 2;

   localparam logic [1:0] SYNC_DATA = 2'b10;
   localparam logic [1:0] SYNC_CTRL = 2'b01;

   // One output word of slack on top of a full block lets a push and a pop share a cycle.
   function automatic int calc_buf_w(input int data_w, input int block_w, input int head_w);
      return data_w + block_w + head_w;
   endfunction

endpackage

// File: rtl/gearbox_tx_gen_if.sv
// Block-in / word-out handshake bundle of the transmit gearbox.
// The slave side is the gearbox itself.
interface gearbox_tx_gen_if
   import gearbox_pkg::*;
#(
   parameter int DATA_W  = 64,
   parameter int BLOCK_W = DEF_BLOCK_W,
   parameter int HEAD_W  = DEF_HEAD_W
);

   logic               in_valid_i;
   logic               in_ready_o;
   logic [HEAD_W-1:0]  head_i;
   logic [BLOCK_W-1:0] data_i;
   logic               out_valid_o;
   logic [DATA_W-1:0]  data_o;

   modport master (
      output in_valid_i,
      output head_i,
      output data_i,
      input  in_ready_o,
      input  out_valid_o,
      input  data_o
   );

   modport slave (
      input  in_valid_i,
      input  head_i,
      input  data_i,
      output in_ready_o,
      output out_valid_o,
      output data_o
   );

endinterface

// File: rtl/gearbox_tx_gen.sv
// 66b -> DATA_W transmit gearbox: packs {data, head} blocks LSB-first into a
// shift buffer and emits a DATA_W word whenever enough bits are buffered.
module gearbox_tx_gen
   import gearbox_pkg::*;
#(
   parameter int BLOCK_W = DEF_BLOCK_W,
   parameter int HEAD_W  = DEF_HEAD_W,
   parameter int DATA_W  = 64
)
(
   input  logic         clk,
   input  logic         reset,
   gearbox_tx_gen_if.slave gb
);

   localparam int BLK_W = BLOCK_W + HEAD_W;
   localparam int BUF_W = calc_buf_w(DATA_W, BLOCK_W, HEAD_W);
   localparam int CNT_W = $clog2(BUF_W + 1);
   // One spare bit so rem + BLK_W cannot wrap for narrow PMA widths.
   localparam int CMP_W = CNT_W + 1;

   if (!(DATA_W == 16 || DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
      $error("gearbox_tx_gen: DATA_W must be 16, 32 or 64");
   end

   logic [BUF_W-1:0]  shift_buf_r;
   logic [CNT_W-1:0]  cnt_r;
   logic [DATA_W-1:0] data_r;
   logic              out_valid_r;

   logic              pop_s;
   logic              ready_s;
   logic              push_s;
   logic [CNT_W-1:0]  rem_s;
   logic [BUF_W-1:0]  shifted_s;
   logic [BUF_W-1:0]  keep_mask_s;
   logic [BUF_W-1:0]  block_s;

   // Occupancy after the pop decides readiness, so ready never depends on in_valid_i.
   always_comb begin
      pop_s = (cnt_r >= CNT_W'(DATA_W));
      if (pop_s) begin
         rem_s     = cnt_r - CNT_W'(DATA_W);
         shifted_s = shift_buf_r >> DATA_W;
      end else begin
         rem_s     = cnt_r;
         shifted_s = shift_buf_r;
      end
      ready_s     = !reset && (({1'b0, rem_s} + CMP_W'(BLK_W)) <= CMP_W'(BUF_W));
      push_s      = gb.in_valid_i && ready_s;
      keep_mask_s = ~({BUF_W{1'b1}} << rem_s);
      block_s     = {{(BUF_W-BLK_W){1'b0}}, gb.data_i, gb.head_i};
   end

   // Shift out the popped word and splice the new block in just above the surviving bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         shift_buf_r <= {BUF_W{1'b0}};
         cnt_r       <= {CNT_W{1'b0}};
         data_r      <= {DATA_W{1'b0}};
         out_valid_r <= 1'b0;
      end else begin
         shift_buf_r <= push_s ? ((shifted_s & keep_mask_s) | (block_s << rem_s)) : shifted_s;
         cnt_r       <= rem_s + (push_s ? CNT_W'(BLK_W) : {CNT_W{1'b0}});
         data_r      <= pop_s ? shift_buf_r[DATA_W-1:0] : data_r;
         out_valid_r <= pop_s;
      end
   end

   assign gb.in_ready_o  = ready_s;
   assign gb.out_valid_o = out_valid_r;
   assign gb.data_o      = data_r;

endmodule

// File: tb/tb_gearbox_tx_gen.sv
// Directed bench for gearbox_tx_gen at all three PMA widths, with a bit-level
// scoreboard rebuilding the serial stream from handshaken blocks.
module tb_gearbox_tx_gen;
   import gearbox_pkg::*;

   logic clk;
   logic reset;

   int errors = 0;
   int checks = 0;

   bit          sb[$];
   logic        rdy;
   logic        ov;
   logic [63:0] dout;
   logic [63:0] last_dout [3];

   gearbox_tx_gen_if #(.DATA_W(64)) if64 ();
   gearbox_tx_gen_if #(.DATA_W(32)) if32 ();
   gearbox_tx_gen_if #(.DATA_W(16)) if16 ();

   gearbox_tx_gen #(.DATA_W(64)) u64 (.clk(clk), .reset(reset), .gb(if64));
   gearbox_tx_gen #(.DATA_W(32)) u32 (.clk(clk), .reset(reset), .gb(if32));
   gearbox_tx_gen #(.DATA_W(16)) u16 (.clk(clk), .reset(reset), .gb(if16));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock on DUT sel (0:64b 1:32b 2:16b); scoreboards the handshake and the output word.
   task automatic cyc(input int sel, input logic v, input logic [1:0] h, input logic [63:0] d);
      int          w;
      logic [63:0] e;
      w = (sel == 0) ? 64 : (sel == 1) ? 32 : 16;
      case (sel)
         0: begin if64.in_valid_i = v; if64.head_i = h; if64.data_i = d; end
         1: begin if32.in_valid_i = v; if32.head_i = h; if32.data_i = d; end
         default: begin if16.in_valid_i = v; if16.head_i = h; if16.data_i = d; end
      endcase
      #1;
      case (sel)
         0: rdy = if64.in_ready_o;
         1: rdy = if32.in_ready_o;
         default: rdy = if16.in_ready_o;
      endcase
      if (v && rdy) begin
         for (int i = 0; i < 2; i++) sb.push_back(h[i]);
         for (int i = 0; i < 64; i++) sb.push_back(d[i]);
      end
      @(posedge clk);
      #1;
      case (sel)
         0: begin ov = if64.out_valid_o; dout = if64.data_o; end
         1: begin ov = if32.out_valid_o; dout = 64'(if32.data_o); end
         default: begin ov = if16.out_valid_o; dout = 64'(if16.data_o); end
      endcase
      if (ov) begin
         e = 64'd0;
         for (int i = 0; i < w; i++) e[i] = (sb.size() > 0) ? sb.pop_front() : 1'bx;
         chk("stream_word", dout, e);
      end else begin
         chk("hold_on_bubble", dout, last_dout[sel]);
      end
      last_dout[sel] = dout;
      case (sel)
         0: if64.in_valid_i = 1'b0;
         1: if32.in_valid_i = 1'b0;
         default: if16.in_valid_i = 1'b0;
      endcase
   endtask

   // One-cycle reset on all DUTs; the 64b DUT sees in_valid_i held high throughout.
   task automatic do_reset(input logic [63:0] d);
      reset = 1'b1;
      if64.in_valid_i = 1'b1; if64.head_i = SYNC_DATA; if64.data_i = d;
      if32.in_valid_i = 1'b0;
      if16.in_valid_i = 1'b0;
      #1;
      chk("rst_ready64", 64'(if64.in_ready_o), 64'd0);
      chk("rst_ready32", 64'(if32.in_ready_o), 64'd0);
      chk("rst_ready16", 64'(if16.in_ready_o), 64'd0);
      @(posedge clk);
      #1;
      chk("rst_ov64", 64'(if64.out_valid_o), 64'd0);
      chk("rst_do64", if64.data_o, 64'd0);
      chk("rst_ov32", 64'(if32.out_valid_o), 64'd0);
      chk("rst_do32", 64'(if32.data_o), 64'd0);
      chk("rst_ov16", 64'(if16.out_valid_o), 64'd0);
      chk("rst_do16", 64'(if16.data_o), 64'd0);
      reset = 1'b0;
      if64.in_valid_i = 1'b0;
      sb.delete();
      for (int i = 0; i < 3; i++) last_dout[i] = 64'd0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [63:0] d;
      logic [63:0] dconst;
      logic [15:0] first16;
      int          c;
      int          pushed;
      int          win;

      reset = 1'b1;
      if64.in_valid_i = 1'b0; if64.head_i = 2'b00; if64.data_i = 64'd0;
      if32.in_valid_i = 1'b0; if32.head_i = 2'b00; if32.data_i = 64'd0;
      if16.in_valid_i = 1'b0; if16.head_i = 2'b00; if16.data_i = 64'd0;
      @(posedge clk);
      #1;
      do_reset(64'd0);

      // 64b sustained: data changes every cycle, so a rejected value would corrupt the stream.
      c = 0;
      pushed = 0;
      while (pushed < 66 && c < 200) begin
         c++;
         d = {$urandom, $urandom};
         cyc(0, 1'b1, d[0] ? SYNC_DATA : SYNC_CTRL, d);
         chk("ready64_cycle", 64'(rdy), 64'(!(c == 34 || c == 67)));
         chk("ovalid64_sustained", 64'(ov), 64'(c != 1));
         if (rdy) pushed++;
      end
      chk("pushes64", 64'(pushed), 64'd66);
      for (int i = 0; i < 3; i++) cyc(0, 1'b0, 2'b00, 64'd0);
      do_reset(64'd0);

      // 32b sustained: 16 pushes in the second 33-cycle window, no bubbles after first pop.
      win = 0;
      for (c = 1; c <= 66; c++) begin
         d = {$urandom, $urandom};
         cyc(1, 1'b1, d[1] ? SYNC_DATA : SYNC_CTRL, d);
         if (rdy && c >= 34) win++;
         chk("ovalid32_sustained", 64'(ov), 64'(c != 1));
      end
      chk("pushes32_window", 64'(win), 64'd16);
      do_reset(64'd0);

      // 16b with a fixed data block.
      dconst  = 64'h0123_4567_89AB_CDEF;
      first16 = {dconst[13:0], 2'b10};
      for (c = 1; c <= 20; c++) begin
         cyc(2, 1'b1, SYNC_DATA, dconst);
         if (c == 2) begin
            chk("first16_valid", 64'(ov), 64'd1);
            chk("first16_word", dout, 64'(first16));
         end
      end
      do_reset(64'd0);

      // Starvation: 5 blocks, 3 idle cycles, then resume.
      for (c = 1; c <= 14; c++) begin
         d = {$urandom, $urandom};
         cyc(0, !(c >= 6 && c <= 8), SYNC_DATA, d);
         chk("ovalid64_starve", 64'(ov), 64'((c >= 2 && c <= 6) || c >= 10));
      end
      do_reset(64'd0);

      // Mid-stream reset after 10 blocks, then a fresh block must start at bit 0.
      for (c = 1; c <= 10; c++) begin
         d = {$urandom, $urandom};
         cyc(0, 1'b1, SYNC_DATA, d);
      end
      do_reset({$urandom, $urandom});
      d = {$urandom, $urandom};
      cyc(0, 1'b1, SYNC_CTRL, d);
      chk("post_rst_push", 64'(rdy), 64'd1);
      cyc(0, 1'b0, 2'b00, 64'd0);
      chk("post_rst_valid", 64'(ov), 64'd1);
      chk("post_rst_head", 64'(dout[1:0]), 64'(SYNC_CTRL));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
